// File: rtl/cdb_broadcaster_pkg.sv
// Shared types and widths for the common data bus transmit side.
package cdb_broadcaster_pkg;
  localparam int ROB_TAG_LEN = 5;
  localparam int XLEN        = 32;
  localparam int CDB_NUM_FU  = 4;

  typedef struct packed {
    logic [ROB_TAG_LEN-1:0] rob_tag;
    logic [XLEN-1:0]        data;
    logic [XLEN-1:0]        target_pc;
    logic                   mispredict;
  } CDB_PACKET;
endpackage

// File: rtl/cdb_result_fifo.sv
// Per-FU result FIFO: push/pop/flush, exposes registered count, head and full.
module cdb_result_fifo
  import cdb_broadcaster_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  CDB_PACKET                  push_pkt,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     count,
  output CDB_PACKET                  head,
  output logic                       full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  CDB_PACKET       mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign head    = mem[rd_ptr];
  // flush wins over any same-cycle push or pop
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && (count != '0) && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_pkt;
  end
endmodule

// File: rtl/cdb_broadcaster.sv
// CDB transmit side: per-FU result FIFOs, round-robin arbiter, registered broadcast.
module cdb_broadcaster
  import cdb_broadcaster_pkg::*;
#(
  parameter int NUM_FU    = CDB_NUM_FU,
  parameter int BUF_DEPTH = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic [NUM_FU-1:0]                    fu_valid,
  output logic [NUM_FU-1:0]                    fu_ready,
  input  logic [NUM_FU-1:0][ROB_TAG_LEN-1:0]   fu_rob_tag,
  input  logic [NUM_FU-1:0][XLEN-1:0]          fu_data,
  input  logic [NUM_FU-1:0][XLEN-1:0]          fu_target_pc,
  input  logic [NUM_FU-1:0]                    fu_mispredict,
  output logic                                 cdb_valid,
  output logic [ROB_TAG_LEN-1:0]               cdb_rob_tag,
  output logic [XLEN-1:0]                      cdb_data,
  output logic [XLEN-1:0]                      cdb_target_pc,
  output logic                                 cdb_mispredict,
  output logic [$clog2(NUM_FU)-1:0]            cdb_fu_id
);
  localparam int ID_W = $clog2(NUM_FU);
  localparam int CW   = $clog2(BUF_DEPTH) + 1;

  logic [NUM_FU-1:0][CW-1:0] count;
  CDB_PACKET [NUM_FU-1:0]    head;
  logic [NUM_FU-1:0]         full, eligible, pop;
  logic [ID_W-1:0]           rr_ptr, winner, rr_next;
  logic                      any_elig;

  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
    cdb_result_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .push     (fu_valid[gi]),
      .push_pkt ('{rob_tag: fu_rob_tag[gi], data: fu_data[gi],
                   target_pc: fu_target_pc[gi], mispredict: fu_mispredict[gi]}),
      .pop      (pop[gi]),
      .count    (count[gi]),
      .head     (head[gi]),
      .full     (full[gi])
    );
    assign eligible[gi] = (count[gi] != '0);
  end

  assign fu_ready = ~full;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    logic [ID_W:0] sum;
    winner   = '0;
    any_elig = 1'b0;
    sum      = '0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_FU)) sum = sum - (ID_W+1)'(NUM_FU);
      if (eligible[sum[ID_W-1:0]]) begin
        winner   = sum[ID_W-1:0];
        any_elig = 1'b1;
      end
    end
  end

  assign rr_next = (winner == ID_W'(NUM_FU - 1)) ? '0 : winner + 1'b1;
  assign pop     = any_elig ? (NUM_FU'(1) << winner) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr         <= '0;
      cdb_valid      <= 1'b0;
      cdb_rob_tag    <= '0;
      cdb_data       <= '0;
      cdb_target_pc  <= '0;
      cdb_mispredict <= 1'b0;
      cdb_fu_id      <= '0;
    end else if (flush) begin
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
    end else if (any_elig) begin
      rr_ptr         <= rr_next;
      cdb_valid      <= 1'b1;
      cdb_rob_tag    <= head[winner].rob_tag;
      cdb_data       <= head[winner].data;
      cdb_target_pc  <= head[winner].target_pc;
      cdb_mispredict <= head[winner].mispredict;
      cdb_fu_id      <= winner;
    end else begin
      cdb_valid <= 1'b0;
    end
  end
endmodule
